// File: rtl/rdma_xmit_arbiter.sv
// Packet-granular round-robin arbiter merging two AXI-Stream RDMA sources
// onto one transmit stream. A granted source owns the output until its TLAST
// beat is accepted. Arbitration spends one IDLE cycle per packet.
module rdma_xmit_arbiter #(
   parameter int DATA_WBITS = 512,
   parameter int DATA_WBYTS = DATA_WBITS/8
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  enable,
   input  logic [DATA_WBITS-1:0] S0_TDATA,
   input  logic [DATA_WBYTS-1:0] S0_TKEEP,
   input  logic                  S0_TVALID,
   input  logic                  S0_TLAST,
   output logic                  S0_TREADY,
   input  logic [DATA_WBITS-1:0] S1_TDATA,
   input  logic [DATA_WBYTS-1:0] S1_TKEEP,
   input  logic                  S1_TVALID,
   input  logic                  S1_TLAST,
   output logic                  S1_TREADY,
   output logic [DATA_WBITS-1:0] M_TDATA,
   output logic [DATA_WBYTS-1:0] M_TKEEP,
   output logic                  M_TVALID,
   output logic                  M_TLAST,
   input  logic                  M_TREADY,
   output logic                  busy,
   output logic [31:0]           pkt_count0,
   output logic [31:0]           pkt_count1
);

   typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

   state_t      state, state_nxt;
   logic        grant, grant_nxt;
   logic        last_grant, last_grant_nxt;
   logic        sel;
   logic        inc0, inc1;
   logic [31:0] cnt0, cnt1;

   assign pkt_count0 = cnt0;
   assign pkt_count1 = cnt1;

   // State register plus grant bookkeeping; last_grant resets to 1 so
   // source 0 wins the first contested arbitration.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= IDLE;
         grant      <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         state      <= state_nxt;
         grant      <= grant_nxt;
         last_grant <= last_grant_nxt;
      end
   end

   // Completed-packet counters; they wrap naturally at 2^32.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt0 <= '0;
         cnt1 <= '0;
      end else begin
         if (inc0) cnt0 <= cnt0 + 32'd1;
         if (inc1) cnt1 <= cnt1 + 32'd1;
      end
   end

   // Next-state, arbitration and output mux. Outputs depend only on state,
   // grant and the source/ready inputs; M_TREADY reaches only S[grant]_TREADY.
   always_comb begin
      state_nxt      = state;
      grant_nxt      = grant;
      last_grant_nxt = last_grant;
      sel            = 1'b0;
      inc0           = 1'b0;
      inc1           = 1'b0;
      busy           = 1'b0;
      M_TDATA        = S0_TDATA;
      M_TKEEP        = S0_TKEEP;
      M_TLAST        = S0_TLAST;
      M_TVALID       = 1'b0;
      S0_TREADY      = 1'b0;
      S1_TREADY      = 1'b0;
      case (state)
         IDLE: begin
            // Contested: pick the source that did not win last time.
            if (S0_TVALID && S1_TVALID) sel = ~last_grant;
            else                        sel = S1_TVALID;
            if (enable && (S0_TVALID || S1_TVALID)) begin
               grant_nxt      = sel;
               last_grant_nxt = sel;
               state_nxt      = XFER;
            end
         end
         XFER: begin
            busy = 1'b1;
            if (grant) begin
               M_TDATA   = S1_TDATA;
               M_TKEEP   = S1_TKEEP;
               M_TLAST   = S1_TLAST;
               M_TVALID  = S1_TVALID;
               S1_TREADY = M_TREADY;
            end else begin
               M_TDATA   = S0_TDATA;
               M_TKEEP   = S0_TKEEP;
               M_TLAST   = S0_TLAST;
               M_TVALID  = S0_TVALID;
               S0_TREADY = M_TREADY;
            end
            // Packet ends only when its TLAST beat is accepted downstream.
            if (M_TVALID && M_TREADY && M_TLAST) begin
               state_nxt = IDLE;
               inc0      = ~grant;
               inc1      = grant;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
